song_sequencer: RTL and testbench
=================================

SONG_SEQUENCER -- requirements
Module: song_sequencer

Interface
REQ-001 SHALL have parameter BEAT_DIV, default 6250000, clk cycles per beat (min 2).
REQ-002 SHALL have parameter COUNTIN_BEATS, default 4, silent beats before first note (0 allowed).
REQ-003 SHALL have port clk  in  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  in  1  synchronous, active-low reset.
REQ-005 SHALL have port start  in  1  one-cycle pulse from menu controller requesting song start.
REQ-006 SHALL have port song  in  2  song index; sampled only on the cycle start=1.
REQ-007 SHALL have port menu_state  in  3  menu controller state; 3'b111 means in-game.
REQ-008 SHALL have port note  out  4  current expected note; 4'h0 when no note is active.
REQ-009 SHALL have port note_valid  out  1  high while a note is active in PLAY.
REQ-010 SHALL have port beat  out  1  one-cycle pulse on every beat boundary in COUNTIN and PLAY.
REQ-011 SHALL have port done  out  1  level; song finished, returned to menu controller.

Function
REQ-012 SHALL implement states IDLE, COUNTIN, PLAY, DONE.
REQ-013 IDLE: start=1 SHALL latch song, clear the beat counter and note pointer, and enter COUNTIN next cycle.
REQ-014 Beat counter SHALL count 0..BEAT_DIV-1 in COUNTIN and PLAY and assert beat for one cycle on wrap to 0.
REQ-015 COUNTIN SHALL last exactly COUNTIN_BEATS beats; with COUNTIN_BEATS=0 it SHALL pass to PLAY after one cycle.
REQ-016 Song ROM SHALL hold 4 songs x 64 entries {dur[3:0], note[3:0]}; address = {song, ptr[5:0]}; one-cycle read latency.
REQ-017 PLAY: each entry SHALL drive note/note_valid for dur beats, with dur=0 treated as 1, then advance ptr by 1.
REQ-018 Entry with note=4'hF SHALL be the end marker: no note is shown and the block enters DONE on the next cycle.
REQ-019 Pointer wrap from 63 to 0 without a marker SHALL force DONE.
REQ-020 Song index 3 SHALL be valid ROM content; an empty song (marker at entry 0) SHALL reach DONE with note_valid never asserted.
REQ-021 DONE: done SHALL be held at 1, note/note_valid at 0, until menu_state != 3'b111, then IDLE next cycle.
REQ-022 start in COUNTIN, PLAY or DONE SHALL restart from REQ-013 with the newly sampled song; done SHALL drop the same cycle.
REQ-023 menu_state != 3'b111 while in COUNTIN or PLAY SHALL abort to IDLE next cycle with done=0.
REQ-024 start and abort condition in the same cycle: start SHALL win.
REQ-025 note SHALL update no later than the ROM latency after the beat pulse; note_valid and note SHALL always change together.

Reset
REQ-026 reset_n=0 SHALL force IDLE, ptr=0, beat counter=0, note=0, note_valid=0, beat=0, done=0, latched song=0, overriding all inputs.
REQ-027 Reset asserted mid-song SHALL abandon the song with no done assertion.

Configuration
REQ-028 Macro SEQ_TEMPO_SCALE_EN, when defined, SHALL add input tempo[1:0] and scale each beat to BEAT_DIV>>tempo cycles, sampled at each beat wrap.
REQ-029 Without SEQ_TEMPO_SCALE_EN, tempo SHALL not exist and each beat SHALL be BEAT_DIV cycles.

Structure
REQ-030 Shared package SHALL hold the state encoding, IN_GAME=3'b111, NOTE_END=4'hF, NOTE_NONE=4'h0, and ROM entry field widths.
REQ-031 ROM SHALL be sub-module song_rom (synchronous read, 256x8, contents from an init file).

Verification
REQ-032 BEAT_DIV=4, COUNTIN_BEATS=4, song 0 = {2,C},{1,E},{0,F} -> beat every 4 cycles; 16 cycles with no note; C shown for 8 cycles, then E for 4, then done=1.
REQ-033 done=1 with menu_state held 3'b111 for 20 cycles -> done stays 1; menu_state=3'b000 -> IDLE next cycle, done=0.
REQ-034 start with song=1 in PLAY, ptr=5 -> ptr=0, COUNTIN restarts, song 1 notes are played.
REQ-035 menu_state drops to 3'b000 mid-PLAY -> IDLE next cycle, note_valid=0, done never asserted.
REQ-036 reset_n=0 for 1 cycle mid-PLAY -> every output is 0 next cycle; a following start plays from entry 0.
REQ-037 Song 3 with marker at entry 0, COUNTIN_BEATS=0 -> done=1 within 4 cycles of start, note_valid never 1.

Source files
------------

// File: rtl/song_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// song_sequencer_pkg
// Shared definitions for the song sequencer:
//   - sequencer state encoding
//   - menu "in-game" code and the special note codes (end marker, silence)
//   - song ROM geometry and entry layout {dur[3:0], note[3:0]}
//   - song_rom_init(): the ROM init table (4 songs x 64 entries)
// ---------------------------------------------------------------------------
package song_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COUNTIN = 2'd1,
    ST_PLAY    = 2'd2,
    ST_DONE    = 2'd3
  } seq_state_e;

  localparam logic [2:0] IN_GAME   = 3'b111;
  localparam logic [3:0] NOTE_END  = 4'hF;
  localparam logic [3:0] NOTE_NONE = 4'h0;

  localparam int DUR_W   = 4;
  localparam int NOTE_W  = 4;
  localparam int SONG_W  = 2;
  localparam int PTR_W   = 6;
  localparam int ADDR_W  = SONG_W + PTR_W;
  localparam int ENTRY_W = DUR_W + NOTE_W;

  typedef struct packed {
    logic [DUR_W-1:0]  dur;
    logic [NOTE_W-1:0] note;
  } rom_entry_t;

  // ROM init table. Unlisted entries hold the end marker, so every song
  // terminates even if its listed part is short.
  //   song 0 : {2,C} {1,E} end
  //   song 1 : short melody, includes a dur=0 entry
  //   song 2 : 64 entries without a marker (exercises pointer wrap)
  //   song 3 : empty (marker at entry 0)
  function automatic rom_entry_t song_rom_init(input logic [ADDR_W-1:0] addr);
    rom_entry_t  e;
    int unsigned idx_v;
    idx_v = {26'd0, addr[PTR_W-1:0]};
    e     = rom_entry_t'({4'h0, NOTE_END});
    case (addr[ADDR_W-1:PTR_W])
      2'd0: begin
        case (addr[PTR_W-1:0])
          6'd0:    e = rom_entry_t'(8'h21);
          6'd1:    e = rom_entry_t'(8'h13);
          default: e = rom_entry_t'({4'h0, NOTE_END});
        endcase
      end
      2'd1: begin
        case (addr[PTR_W-1:0])
          6'd0:    e = rom_entry_t'(8'h15);
          6'd1:    e = rom_entry_t'(8'h06);
          6'd2:    e = rom_entry_t'(8'h38);
          6'd3:    e = rom_entry_t'(8'h1A);
          6'd4:    e = rom_entry_t'(8'h22);
          6'd5:    e = rom_entry_t'(8'h1C);
          6'd6:    e = rom_entry_t'(8'h24);
          default: e = rom_entry_t'({4'h0, NOTE_END});
        endcase
      end
      2'd2: begin
        // Notes 1..12 only, so no entry of this song is ever a marker.
        e.dur  = DUR_W'(idx_v % 32'd3);
        e.note = NOTE_W'((idx_v % 32'd12) + 32'd1);
      end
      default: e = rom_entry_t'({4'h0, NOTE_END});
    endcase
    return e;
  endfunction

endpackage

// File: rtl/song_sequencer_rom.sv
// ---------------------------------------------------------------------------
// song_rom
// 256 x 8 synchronous-read song ROM, contents from song_rom_init().
// Ports:
//   clk  in  1  rising-edge clock
//   addr in  8  {song[1:0], ptr[5:0]}
//   data out 8  {dur[3:0], note[3:0]} of the address presented last cycle
// ---------------------------------------------------------------------------
module song_rom
  import song_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic [ADDR_W-1:0]  addr,
  output logic [ENTRY_W-1:0] data
);

  logic [ENTRY_W-1:0] data_q;

  // Registered read port: one cycle of latency.
  always_ff @(posedge clk) begin
    data_q <= song_rom_init(addr);
  end

  assign data = data_q;

endmodule

// File: rtl/song_sequencer.sv
// ---------------------------------------------------------------------------
// song_sequencer
// Plays one of four ROM songs: a silent count-in, then each ROM entry is
// shown on note/note_valid for its duration in beats, until an end marker
// or pointer wrap finishes the song.
// Parameters:
//   BEAT_DIV       clk cycles per beat (min 2)
//   COUNTIN_BEATS  silent beats before the first note (0 allowed)
// Ports:
//   clk         in   1  clock, rising edge
//   reset_n     in   1  synchronous active-low reset
//   start       in   1  song start request pulse (restarts when busy)
//   song        in   2  song index, sampled with start
//   menu_state  in   3  menu controller state, 3'b111 = in-game
//   tempo       in   2  only with SEQ_TEMPO_SCALE_EN: beat = BEAT_DIV>>tempo
//   note        out  4  current note, 0 when none
//   note_valid  out  1  note active
//   beat        out  1  pulse on each beat boundary
//   done        out  1  song finished (held until menu leaves in-game)
// Optional feature macro: SEQ_TEMPO_SCALE_EN
// ---------------------------------------------------------------------------
module song_sequencer
  import song_sequencer_pkg::*;
#(
  parameter int BEAT_DIV      = 6250000,
  parameter int COUNTIN_BEATS = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [SONG_W-1:0] song,
  input  logic [2:0]        menu_state,
`ifdef SEQ_TEMPO_SCALE_EN
  input  logic [1:0]        tempo,
`endif
  output logic [NOTE_W-1:0] note,
  output logic              note_valid,
  output logic              beat,
  output logic              done
);

  localparam int               CNT_W    = (BEAT_DIV > 2) ? $clog2(BEAT_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BEAT_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam int               CB_W     = (COUNTIN_BEATS > 2) ? $clog2(COUNTIN_BEATS) : 1;
  localparam logic [CB_W-1:0]  CB_LAST  = (COUNTIN_BEATS > 0) ? CB_W'(COUNTIN_BEATS - 1) : CB_W'(0);
  localparam logic [CB_W-1:0]  CB_ONE   = CB_W'(1);
  localparam bit               CI_ZERO  = (COUNTIN_BEATS == 0);
  localparam logic [PTR_W-1:0] PTR_LAST = {PTR_W{1'b1}};
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [DUR_W-1:0] DUR_ONE  = DUR_W'(1);

  seq_state_e        state_q, state_d;
  logic [SONG_W-1:0] song_q, song_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CB_W-1:0]   cbeat_q, cbeat_d;
  logic [DUR_W-1:0]  left_q, left_d;
  logic              last_q, last_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic              valid_q, valid_d;
  logic              beat_q, beat_d;
  logic              done_q, done_d;

  logic [CNT_W-1:0]   cnt_max_s;
  logic [CNT_W-1:0]   cnt_next_s;
  logic               wrap_s;
  logic               load_s;
  logic               finish_s;
  logic               running_s;
  logic [ADDR_W-1:0]  rom_addr_s;
  logic [ENTRY_W-1:0] rom_data_s;
  rom_entry_t         rom_entry_s;

`ifdef SEQ_TEMPO_SCALE_EN
  logic [CNT_W-1:0] cnt_max_q, cnt_max_d;

  // Last counter value of a beat at the given tempo; never below one cycle.
  function automatic logic [CNT_W-1:0] tempo_max(input logic [1:0] t);
    int len;
    len = BEAT_DIV >> t;
    if (len < 1) begin
      len = 1;
    end else begin
      len = len;
    end
    return CNT_W'(len - 1);
  endfunction

  assign cnt_max_s = cnt_max_q;
`else
  assign cnt_max_s = CNT_MAX;
`endif

  // The ROM is addressed with next-cycle values so its output always matches
  // the registered song/pointer; an entry can be consumed the cycle after
  // start or after the pointer advances.
  assign rom_addr_s  = {song_d, ptr_d};
  assign rom_entry_s = rom_entry_t'(rom_data_s);

  song_rom u_rom (
    .clk  (clk),
    .addr (rom_addr_s),
    .data (rom_data_s)
  );

  assign wrap_s     = (cnt_q >= cnt_max_s);
  assign cnt_next_s = wrap_s ? CNT_W'(0) : (cnt_q + CNT_ONE);
  assign running_s  = (state_q == ST_COUNTIN) || (state_q == ST_PLAY);

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d  = state_q;
    song_d   = song_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    cbeat_d  = cbeat_q;
    left_d   = left_q;
    last_d   = last_q;
    note_d   = note_q;
    valid_d  = valid_q;
    beat_d   = 1'b0;
    done_d   = done_q;
    load_s   = 1'b0;
    finish_s = 1'b0;
`ifdef SEQ_TEMPO_SCALE_EN
    cnt_max_d = cnt_max_q;
`endif

    case (state_q)
      ST_IDLE: begin
        note_d  = NOTE_NONE;
        valid_d = 1'b0;
        done_d  = 1'b0;
      end
      ST_COUNTIN: begin
        cnt_d  = cnt_next_s;
        beat_d = wrap_s;
        if (CI_ZERO) begin
          // No count-in: go straight to the first entry and start the
          // beat grid fresh from it.
          cnt_d  = CNT_W'(0);
          beat_d = 1'b0;
          load_s = 1'b1;
        end else if (wrap_s) begin
          if (cbeat_q == CB_LAST) begin
            load_s = 1'b1;
          end else begin
            cbeat_d = cbeat_q + CB_ONE;
          end
        end else begin
          cbeat_d = cbeat_q;
        end
      end
      ST_PLAY: begin
        cnt_d  = cnt_next_s;
        beat_d = wrap_s;
        if (wrap_s) begin
          if (left_q <= DUR_ONE) begin
            // Entry 63 was already consumed: the pointer wrapped, song over.
            if (last_q) begin
              finish_s = 1'b1;
            end else begin
              load_s = 1'b1;
            end
          end else begin
            left_d = left_q - DUR_ONE;
          end
        end else begin
          left_d = left_q;
        end
      end
      ST_DONE: begin
        if (menu_state != IN_GAME) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end else begin
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef SEQ_TEMPO_SCALE_EN
    if (running_s && wrap_s) begin
      cnt_max_d = tempo_max(tempo);
    end else begin
      cnt_max_d = cnt_max_q;
    end
`endif

    // Consume the ROM entry at ptr_q; the pointer moves on immediately so the
    // next entry is fetched while this one plays.
    if (load_s) begin
      if (rom_entry_s.note == NOTE_END) begin
        finish_s = 1'b1;
      end else begin
        state_d = ST_PLAY;
        note_d  = rom_entry_s.note;
        valid_d = 1'b1;
        left_d  = (rom_entry_s.dur == DUR_W'(0)) ? DUR_ONE : rom_entry_s.dur;
        last_d  = (ptr_q == PTR_LAST);
        ptr_d   = ptr_q + PTR_ONE;
      end
    end else begin
      ptr_d = ptr_d;
    end

    if (finish_s) begin
      state_d = ST_DONE;
      note_d  = NOTE_NONE;
      valid_d = 1'b0;
      done_d  = 1'b1;
    end else begin
      done_d = done_d;
    end

    // Leaving the game mid-song abandons it silently.
    if (running_s && (menu_state != IN_GAME)) begin
      state_d = ST_IDLE;
      note_d  = NOTE_NONE;
      valid_d = 1'b0;
      beat_d  = 1'b0;
      done_d  = 1'b0;
      cnt_d   = CNT_W'(0);
    end else begin
      state_d = state_d;
    end

    // start has the highest priority of all inputs except reset.
    if (start) begin
      state_d = ST_COUNTIN;
      song_d  = song;
      ptr_d   = PTR_W'(0);
      cnt_d   = CNT_W'(0);
      cbeat_d = CB_W'(0);
      left_d  = DUR_W'(0);
      last_d  = 1'b0;
      note_d  = NOTE_NONE;
      valid_d = 1'b0;
      beat_d  = 1'b0;
      done_d  = 1'b0;
`ifdef SEQ_TEMPO_SCALE_EN
      cnt_max_d = tempo_max(tempo);
`endif
    end else begin
      song_d = song_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      song_q  <= SONG_W'(0);
      ptr_q   <= PTR_W'(0);
      cnt_q   <= CNT_W'(0);
      cbeat_q <= CB_W'(0);
      left_q  <= DUR_W'(0);
      last_q  <= 1'b0;
      note_q  <= NOTE_NONE;
      valid_q <= 1'b0;
      beat_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_TEMPO_SCALE_EN
      cnt_max_q <= CNT_MAX;
`endif
    end else begin
      state_q <= state_d;
      song_q  <= song_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      cbeat_q <= cbeat_d;
      left_q  <= left_d;
      last_q  <= last_d;
      note_q  <= note_d;
      valid_q <= valid_d;
      beat_q  <= beat_d;
      done_q  <= done_d;
`ifdef SEQ_TEMPO_SCALE_EN
      cnt_max_q <= cnt_max_d;
`endif
    end
  end

  assign note       = note_q;
  assign note_valid = valid_q;
  assign beat       = beat_q;
  assign done       = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// ---------------------------------------------------------------------------
// tb_song_sequencer
// Two sequencers (BEAT_DIV=4/COUNTIN=4 and BEAT_DIV=3/COUNTIN=0) share one
// stimulus stream. A reference model turns each start into the complete
// expected output timeline of the song and replays it cycle by cycle, with
// aborts, done exit and reset applied on top. Directed literal checks pin
// the key timing points; a random phase follows.
// ---------------------------------------------------------------------------
module tb_song_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [1:0] song;
  logic [2:0] menu_state;

  logic [3:0] note_a, note_b;
  logic       valid_a, valid_b, beat_a, beat_b, done_a, done_b;

  always #5 clk = ~clk;

  song_sequencer #(.BEAT_DIV(4), .COUNTIN_BEATS(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start), .song(song),
    .menu_state(menu_state), .note(note_a), .note_valid(valid_a),
    .beat(beat_a), .done(done_a)
  );

  song_sequencer #(.BEAT_DIV(3), .COUNTIN_BEATS(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start), .song(song),
    .menu_state(menu_state), .note(note_b), .note_valid(valid_b),
    .beat(beat_b), .done(done_b)
  );

  typedef struct packed {
    logic [3:0] note;
    logic       valid;
    logic       beat;
    logic       done;
  } exp_t;

  logic [7:0] rom_m [0:255];
  exp_t       tl [0:1][0:1023];
  int         tl_len [2];
  int         idx [2];
  bit         run [2];
  int         bd_m [2];
  int         cb_m [2];
  int         tests = 0;
  int         fails = 0;
  bit         chk_en = 1'b0;
  int         cyc = 0;

  task automatic push(input int m, input logic [3:0] nt, input logic v,
                      input logic b, input logic d);
    if (tl_len[m] < 1024) begin
      tl[m][tl_len[m]] = {nt, v, b, d};
      tl_len[m]++;
    end
  endtask

  // Whole-song expected output, one element per cycle starting the cycle
  // after start is sampled; the last element is the first done cycle.
  task automatic build(input int m, input int s);
    int         bd, cb, d;
    logic [7:0] e;
    bit         bnd, first, marker;
    bd = bd_m[m];
    cb = cb_m[m];
    tl_len[m] = 0;
    if (cb == 0) push(m, 4'h0, 1'b0, 1'b0, 1'b0);
    else for (int k = 0; k < cb * bd; k++)
      push(m, 4'h0, 1'b0, (k > 0) && (k % bd == 0), 1'b0);
    first  = 1'b1;
    marker = 1'b0;
    bnd    = 1'b1;
    for (int i = 0; i < 64; i++) begin
      e     = rom_m[s * 64 + i];
      // Only the very first boundary without a count-in lacks a beat pulse.
      bnd   = !(first && (cb == 0));
      first = 1'b0;
      if (e[3:0] == 4'hF) begin
        marker = 1'b1;
        break;
      end
      d = (e[7:4] == 4'h0) ? 1 : int'(e[7:4]);
      for (int j = 0; j < d * bd; j++)
        push(m, e[3:0], 1'b1, (j == 0) ? bnd : (j % bd == 0), 1'b0);
    end
    if (!marker) bnd = 1'b1;
    push(m, 4'h0, 1'b0, bnd, 1'b1);
  endtask

  function automatic exp_t expect_of(input int m);
    if (!run[m]) return '0;
    else if (idx[m] < tl_len[m]) return tl[m][idx[m]];
    else return {4'h0, 1'b0, 1'b0, 1'b1};
  endfunction

  // Reference model advances on each rising edge from the sampled inputs.
  always @(posedge clk) begin
    cyc++;
    for (int m = 0; m < 2; m++) begin
      if (!reset_n) run[m] = 1'b0;
      else if (start) begin
        build(m, int'(song));
        run[m] = 1'b1;
        idx[m] = 0;
      end else if (run[m]) begin
        if (menu_state != 3'b111) run[m] = 1'b0;
        else if (idx[m] < tl_len[m]) idx[m]++;
      end
    end
  end

  // Every-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int m = 0; m < 2; m++) begin
        exp_t g, e;
        g = (m == 0) ? {note_a, valid_a, beat_a, done_a} : {note_b, valid_b, beat_b, done_b};
        e = expect_of(m);
        tests++;
        if (g !== e) begin
          fails++;
          $display("FAIL model_cmp inst=%0d cyc=%0d got note=%h valid=%b beat=%b done=%b exp note=%h valid=%b beat=%b done=%b",
                   m, cyc, g.note, g.valid, g.beat, g.done, e.note, e.valid, e.beat, e.done);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  task automatic cyc_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge of the first cycle after start was sampled (k=0).
  task automatic pulse_start(input int s);
    @(negedge clk);
    start = 1'b1;
    song  = 2'(s);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    bit seen_done, seen_valid;
    bd_m[0] = 4; cb_m[0] = 4;
    bd_m[1] = 3; cb_m[1] = 0;
    for (int i = 0; i < 256; i++) rom_m[i] = 8'h0F;
    rom_m[0]  = 8'h21; rom_m[1]  = 8'h13;
    rom_m[64] = 8'h15; rom_m[65] = 8'h06; rom_m[66] = 8'h38; rom_m[67] = 8'h1A;
    rom_m[68] = 8'h22; rom_m[69] = 8'h1C; rom_m[70] = 8'h24; rom_m[71] = 8'h0F;
    for (int i = 0; i < 64; i++) rom_m[128 + i] = {4'(i % 3), 4'(i % 12 + 1)};
    for (int m = 0; m < 2; m++) begin run[m] = 1'b0; idx[m] = 0; tl_len[m] = 0; end

    reset_n = 1'b0; start = 1'b0; song = 2'd0; menu_state = 3'b111;
    cyc_n(3);
    chk("reset_outputs_a", {1'b0, note_a, valid_a, beat_a, done_a}, 8'h00);
    chk("reset_outputs_b", {1'b0, note_b, valid_b, beat_b, done_b}, 8'h00);
    chk_en  = 1'b1;
    reset_n = 1'b1;

    // Song 0 reference timing.
    pulse_start(0);
    chk("model_len_a", 8'(tl_len[0]), 8'd29);
    chk("model_len_b", 8'(tl_len[1]), 8'd11);
    cyc_n(15);
    chk("countin_silent", {3'b000, note_a, valid_a}, 8'h00);
    cyc_n(1);
    chk("first_note_c", {2'b00, note_a, valid_a, beat_a}, 8'h07);
    cyc_n(7);
    chk("c_held_8", {3'b000, note_a, valid_a}, 8'h03);
    cyc_n(1);
    chk("second_note_e", {2'b00, note_a, valid_a, beat_a}, 8'h0F);
    cyc_n(4);
    chk("done_set", {1'b0, note_a, valid_a, beat_a, done_a}, 8'h03);
    for (int i = 0; i < 20; i++) begin
      cyc_n(1);
      chk("done_hold", {7'd0, done_a}, 8'h01);
    end
    @(negedge clk) menu_state = 3'b000;
    @(negedge clk);
    chk("done_exit", {7'd0, done_a}, 8'h00);
    menu_state = 3'b111;

    // Restart with song 1 while song 2 is playing around entry 5.
    pulse_start(2);
    cyc_n(37);
    pulse_start(1);
    cyc_n(16);
    chk("restart_song1", {3'b000, note_a, valid_a}, 8'h0B);

    // Abort mid-play.
    cyc_n(6);
    @(negedge clk) menu_state = 3'b000;
    @(negedge clk);
    chk("abort_idle", {2'b00, note_a, valid_a, done_a}, 8'h00);
    menu_state = 3'b111;
    cyc_n(10);
    chk("abort_no_done", {7'd0, done_a}, 8'h00);

    // One-cycle reset mid-play, then replay from entry 0.
    pulse_start(1);
    cyc_n(20);
    @(negedge clk) reset_n = 1'b0;
    @(negedge clk);
    chk("reset_mid_play", {1'b0, note_a, valid_a, beat_a, done_a}, 8'h00);
    reset_n = 1'b1;
    pulse_start(0);
    cyc_n(16);
    chk("replay_entry0", {3'b000, note_a, valid_a}, 8'h03);

    // Empty song 3.
    pulse_start(3);
    seen_done  = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (done_b) seen_done = 1'b1;
      if (valid_b) seen_valid = 1'b1;
      @(negedge clk);
    end
    chk("empty_song_done", {7'd0, seen_done}, 8'h01);
    chk("empty_song_no_valid", {7'd0, seen_valid}, 8'h00);
    cyc_n(14);
    chk("empty_song_done_a", {7'd0, done_a}, 8'h01);
    @(negedge clk) menu_state = 3'b000;
    @(negedge clk) menu_state = 3'b111;

    // Song 2 has no marker: pointer wrap ends it.
    pulse_start(2);
    cyc_n(400);
    chk("wrap_done_a", {7'd0, done_a}, 8'h01);
    chk("wrap_done_b", {7'd0, done_b}, 8'h01);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      start      = ($urandom_range(0, 39) == 0);
      song       = 2'($urandom_range(0, 3));
      menu_state = ($urandom_range(0, 79) == 0) ? 3'($urandom_range(0, 6)) : 3'b111;
      reset_n    = ($urandom_range(0, 299) != 0);
    end
    @(negedge clk);
    start = 1'b0; reset_n = 1'b1; menu_state = 3'b111;
    cyc_n(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
